// File: rtl/fan_speed_ctrl.sv
// Fan speed sequencer: turns debounced button levels into a 0..5 speed, an optional
// auto-off countdown, and a motor PWM whose duty is speed*20 percent.
module fan_speed_ctrl #(
    parameter int TICK_DIV     = 100_000_000,
    parameter int TIMER_UNIT_S = 10,
    parameter int PWM_DIV      = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_off,
    input  logic       i_btn_timer,
    output logic [5:0] o_fanState,
    output logic [1:0] o_timerSet,
    output logic [7:0] o_timerRemain,
    output logic       o_pwm,
    output logic       o_running,
    output logic [1:0] o_dbg_state
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PWM_DIV_LAST = PW'(PWM_DIV - 1);
    localparam logic [7:0]    REMAIN_1     = 8'(TIMER_UNIT_S);
    localparam logic [7:0]    REMAIN_2     = 8'(2 * TIMER_UNIT_S);
    localparam logic [7:0]    REMAIN_3     = 8'(3 * TIMER_UNIT_S);
    localparam logic [2:0]    SPEED_MAX    = 3'd5;
    localparam logic [6:0]    PWM_CNT_LAST = 7'd99;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        TIMED = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [2:0]    speed, speed_n;
    logic [1:0]    tset, tset_n;
    logic [7:0]    remain, remain_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [3:0]    btn_prev, btn_cur, press;
    logic          p_off, p_up, p_down, p_timer;
    logic [2:0]    speed_inc, speed_dec;
    logic [PW-1:0] pwm_div_cnt;
    logic [6:0]    pwm_cnt, duty;
    logic          pwm_q, running_q;

    // Bit order {off, up, down, timer} doubles as the priority order.
    assign btn_cur   = {i_btn_off, i_btn_up, i_btn_down, i_btn_timer};
    assign press     = btn_cur & ~btn_prev;
    assign p_off     = press[3];
    assign p_up      = press[2] & ~press[3];
    assign p_down    = press[1] & ~(|press[3:2]);
    assign p_timer   = press[0] & ~(|press[3:1]);
    assign speed_inc = (speed == SPEED_MAX) ? SPEED_MAX : speed + 3'd1;
    assign speed_dec = speed - 3'd1;
    assign duty      = 7'(speed) * 7'd20;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            speed    <= 3'd0;
            tset     <= 2'd0;
            remain   <= 8'd0;
            tick_cnt <= '0;
            btn_prev <= 4'd0;
        end else begin
            state    <= state_n;
            speed    <= speed_n;
            tset     <= tset_n;
            remain   <= remain_n;
            tick_cnt <= tick_n;
            btn_prev <= btn_cur;
        end
    end

    // A cycle carrying a press does not advance the countdown; expiry is
    // re-evaluated on the following cycle from the post-press state.
    always_comb begin
        state_n  = state;
        speed_n  = speed;
        tset_n   = tset;
        remain_n = remain;
        tick_n   = tick_cnt;
        case (state)
            IDLE: begin
                tick_n = '0;
                if (p_up) begin
                    speed_n = 3'd1;
                    state_n = RUN;
                end
            end
            RUN: begin
                tick_n = '0;
                if (p_off) begin
                    speed_n = 3'd0;
                    state_n = IDLE;
                end else if (p_up) begin
                    speed_n = speed_inc;
                end else if (p_down) begin
                    speed_n = speed_dec;
                    if (speed == 3'd1) state_n = IDLE;
                end else if (p_timer) begin
                    tset_n   = 2'd1;
                    remain_n = REMAIN_1;
                    state_n  = TIMED;
                end
            end
            TIMED: begin
                if (p_off || (p_down && speed == 3'd1)) begin
                    speed_n  = 3'd0;
                    tset_n   = 2'd0;
                    remain_n = 8'd0;
                    tick_n   = '0;
                    state_n  = IDLE;
                end else if (p_up) begin
                    speed_n = speed_inc;
                end else if (p_down) begin
                    speed_n = speed_dec;
                end else if (p_timer) begin
                    tick_n = '0;
                    if (tset == 2'd3) begin
                        tset_n   = 2'd0;
                        remain_n = 8'd0;
                        state_n  = RUN;
                    end else begin
                        tset_n   = tset + 2'd1;
                        remain_n = (tset == 2'd1) ? REMAIN_2 : REMAIN_3;
                    end
                end else if (tick_cnt == TICK_LAST) begin
                    tick_n = '0;
                    if (remain <= 8'd1) begin
                        speed_n  = 3'd0;
                        tset_n   = 2'd0;
                        remain_n = 8'd0;
                        state_n  = IDLE;
                    end else begin
                        remain_n = remain - 8'd1;
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            default: begin
                speed_n  = 3'd0;
                tset_n   = 2'd0;
                remain_n = 8'd0;
                tick_n   = '0;
                state_n  = IDLE;
            end
        endcase
    end

    // Free-running PWM timebase; a speed change is picked up at the next compare.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pwm_div_cnt <= '0;
            pwm_cnt     <= 7'd0;
            pwm_q       <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            if (pwm_div_cnt == PWM_DIV_LAST) begin
                pwm_div_cnt <= '0;
                pwm_cnt     <= (pwm_cnt == PWM_CNT_LAST) ? 7'd0 : pwm_cnt + 7'd1;
            end else begin
                pwm_div_cnt <= pwm_div_cnt + 1'b1;
            end
            pwm_q     <= (pwm_cnt < duty);
            running_q <= (speed_n != 3'd0);
        end
    end

    assign o_fanState    = {3'b000, speed};
    assign o_timerSet    = tset;
    assign o_timerRemain = remain;
    assign o_pwm         = pwm_q;
    assign o_running     = running_q;
    assign o_dbg_state   = state;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Randomized and directed bench for fan_speed_ctrl with a rule-level reference
// model feeding an expected-output queue drained by an independent monitor.
module tb_fan_speed_ctrl;
    localparam int TICK  = 10;
    localparam int UNIT  = 3;
    localparam bit [3:0] B_OFF  = 4'b1000;
    localparam bit [3:0] B_UP   = 4'b0100;
    localparam bit [3:0] B_DOWN = 4'b0010;
    localparam bit [3:0] B_TMR  = 4'b0001;

    logic       clk;
    logic       i_reset, i_btn_up, i_btn_down, i_btn_off, i_btn_timer;
    logic [5:0] o_fanState;
    logic [1:0] o_timerSet;
    logic [7:0] o_timerRemain;
    logic       o_pwm, o_running;
    logic [1:0] o_dbg_state;

    fan_speed_ctrl #(
        .TICK_DIV     (TICK),
        .TIMER_UNIT_S (UNIT),
        .PWM_DIV      (1)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_btn_up      (i_btn_up),
        .i_btn_down    (i_btn_down),
        .i_btn_off     (i_btn_off),
        .i_btn_timer   (i_btn_timer),
        .o_fanState    (o_fanState),
        .o_timerSet    (o_timerSet),
        .o_timerRemain (o_timerRemain),
        .o_pwm         (o_pwm),
        .o_running     (o_running),
        .o_dbg_state   (o_dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    // reference model: fan behaviour in terms of speed, timer setting and seconds left
    int m_speed = 0, m_set = 0, m_remain = 0, m_tick = 0, m_edge = 0;
    bit [3:0] m_prev = 4'b0;
    bit m_pwm = 1'b0;

    task automatic model_step(input bit rst, input bit [3:0] cur);
        bit [3:0] pr;
        if (rst) begin
            m_speed = 0; m_set = 0; m_remain = 0; m_tick = 0;
            m_edge = 0; m_prev = 4'b0; m_pwm = 1'b0;
        end else begin
            m_pwm = ((m_edge % 100) < m_speed * 20);
            m_edge++;
            pr = cur & ~m_prev;
            m_prev = cur;
            if (pr[3]) begin
                m_speed = 0; m_set = 0; m_remain = 0;
            end else if (pr[2]) begin
                m_speed = (m_speed >= 5) ? 5 : m_speed + 1;
            end else if (pr[1]) begin
                if (m_speed > 0) m_speed--;
                if (m_speed == 0) begin m_set = 0; m_remain = 0; end
            end else if (pr[0]) begin
                if (m_speed > 0) begin
                    m_set = (m_set + 1) % 4;
                    m_remain = m_set * UNIT;
                    m_tick = 0;
                end
            end else if (m_set != 0) begin
                m_tick++;
                if (m_tick == TICK) begin
                    m_tick = 0;
                    m_remain--;
                    if (m_remain == 0) begin m_speed = 0; m_set = 0; end
                end
            end
        end
    endtask

    function automatic logic [19:0] model_outputs();
        logic [1:0] st;
        st = (m_speed == 0) ? 2'd0 : (m_set == 0) ? 2'd1 : 2'd2;
        return {6'(m_speed), 2'(m_set), 8'(m_remain), (m_speed != 0), st, m_pwm};
    endfunction

    // driver tasks: b = {off, up, down, timer}
    task automatic step(input bit rst, input bit [3:0] b);
        @(negedge clk);
        i_reset     = rst;
        i_btn_off   = b[3];
        i_btn_up    = b[2];
        i_btn_down  = b[1];
        i_btn_timer = b[0];
        model_step(rst, b);
        exp_q.push_back(model_outputs());
    endtask

    task automatic pulse(input bit [3:0] b);
        step(1'b0, b);
        step(1'b0, 4'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'b0);
    endtask

    // scoreboard monitor
    logic [19:0] exp_v, act_v;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {o_fanState, o_timerSet, o_timerRemain, o_running, o_dbg_state, o_pwm};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs @%0t: got fan=%0d set=%0d rem=%0d run=%0d st=%0d pwm=%0d, expected fan=%0d set=%0d rem=%0d run=%0d st=%0d pwm=%0d",
                         $time, act_v[19:14], act_v[13:12], act_v[11:4], act_v[3], act_v[2:1], act_v[0],
                         exp_v[19:14], exp_v[13:12], exp_v[11:4], exp_v[3], exp_v[2:1], exp_v[0]);
            end
        end
    end

    // duty-cycle window counter
    bit win_en = 1'b0;
    int win_hi = 0;
    always @(posedge clk) begin
        #1;
        if (win_en && o_pwm === 1'b1) win_hi++;
    end

    task automatic pwm_window(input int exp_hi, input string name);
        win_hi = 0;
        win_en = 1'b1;
        idle(100);
        win_en = 1'b0;
        checks++;
        if (win_hi != exp_hi) begin
            errors++;
            $display("FAIL %s: pwm high %0d of 100 counts, expected %0d", name, win_hi, exp_hi);
        end
    endtask

    task automatic wait_model(input int want_remain, input int want_tick, input string name);
        int k;
        k = 0;
        while (!(m_set != 0 && m_remain == want_remain && (want_tick < 0 || m_tick == want_tick)) && k < 200) begin
            step(1'b0, 4'b0);
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: countdown point not reached, remain=%0d expected %0d", name, m_remain, want_remain);
        end
    endtask

    initial begin
        i_reset = 1'b1; i_btn_up = 1'b0; i_btn_down = 1'b0;
        i_btn_off = 1'b0; i_btn_timer = 1'b0;

        // reset with all buttons held, release together with reset
        repeat (3) step(1'b1, 4'b1111);
        idle(5);

        // held up gives one press, then saturate at 5
        repeat (50) step(1'b0, B_UP);
        idle(1);
        repeat (6) pulse(B_UP);
        pwm_window(100, "pwm_speed5");

        // speed 2 duty, then down through to idle
        repeat (3) pulse(B_DOWN);
        pwm_window(40, "pwm_speed2");
        repeat (4) pulse(B_DOWN);
        pwm_window(0, "pwm_speed0");

        // timer cycling at speed 3
        repeat (3) pulse(B_UP);
        pulse(B_TMR);
        idle(12);
        pulse(B_TMR);
        idle(4);
        pulse(B_TMR);
        pulse(B_TMR);
        idle(5);

        // expiry at speed 4
        pulse(B_UP);
        pulse(B_TMR);
        idle(40);

        // up press in the expiry cycle
        repeat (4) pulse(B_UP);
        pulse(B_TMR);
        wait_model(1, TICK - 1, "expiry_press");
        step(1'b0, B_UP);
        idle(5);

        // reset mid-countdown
        repeat (3) pulse(B_UP);
        pulse(B_TMR);
        wait_model(2, -1, "reset_mid");
        repeat (2) step(1'b1, 4'b0);
        idle(5);

        // simultaneous presses
        repeat (3) pulse(B_UP);
        pulse(B_OFF | B_UP);
        repeat (3) pulse(B_UP);
        pulse(B_UP | B_DOWN);
        pulse(B_DOWN);
        pulse(B_DOWN | B_TMR);
        idle(3);

        // randomized levels with occasional reset
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 149) == 0,
                 {$urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0});
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 25));
        end
        idle(3);

        // final report
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fan_speed_ctrl.md
Name: fan_speed_ctrl

Overview:
Sequencing controller for the fan.
- Turns debounced button levels into a fan state of 0..5 (o_fanState, which feeds the FND value decoder).
- Generates the motor PWM from that state.
- Runs an optional auto-off countdown timer.
- Sits between the debouncers and the FND/motor drivers on the basys3 top level.

Parameters:
TICK_DIV, 100_000_000, clocks per 1 s tick (100 MHz clock).
TIMER_UNIT_S, 10, seconds per timer step.
PWM_DIV, 1000, clocks per PWM counter increment.

Ports:
i_clk  in  1  system clock.
i_reset  in  1  synchronous, active-high reset.
i_btn_up  in  1  debounced level; speed up.
i_btn_down  in  1  debounced level; speed down.
i_btn_off  in  1  debounced level; force off.
i_btn_timer  in  1  debounced level; cycle timer setting.
o_fanState  out  6  current speed, 0..5.
o_timerSet  out  2  timer setting, 0 = none, 1..3 = steps.
o_timerRemain  out  8  seconds remaining (0 when untimed).
o_pwm  out  1  motor PWM.
o_running  out  1  high when o_fanState != 0.

Behaviour:
Reset (i_reset high at a rising edge) sets:
- o_fanState=0, o_timerSet=0, o_timerRemain=0, o_pwm=0, o_running=0.
- FSM=IDLE.
- Edge-detect history, tick counter and PWM counters all 0.
- Reset mid-countdown or mid-PWM-period aborts immediately. No residual state.

Edge detection:
- Each button is registered; press = rising edge (cur & ~prev).
- A held button yields exactly one press.
- Press is acted on in the cycle the edge is seen, so outputs update 1 clock after the level rises.

Priority when several presses occur in the same cycle: off > up > down > timer. Only the highest-priority press is acted on; the others are dropped.

FSM states: IDLE, RUN, TIMED.

IDLE (speed 0):
- up -> speed=1, go to RUN.
- down, off, timer -> ignored.

RUN (speed 1..5, untimed):
- up: speed saturates at 5.
- down: speed-1; at 1 -> speed=0, go to IDLE.
- off -> speed=0, go to IDLE.
- timer -> timerSet=1, remain=TIMER_UNIT_S, tick counter cleared, go to TIMED.

TIMED (speed 1..5, countdown active):
- up/down: same speed rules as RUN. Reaching speed 0 -> IDLE with timerSet=0, remain=0.
- off -> IDLE, timerSet=0, remain=0.
- timer: timerSet=timerSet+1.
  - At 3, wraps to 0 -> go to RUN, remain=0.
  - Otherwise remain=timerSet_new*TIMER_UNIT_S and tick counter cleared.
- Tick counter counts 0..TICK_DIV-1 and only runs in TIMED. On wrap, remain decrements.
- When remain goes 1->0: same cycle speed=0, timerSet=0, go to IDLE.
- If a button press and expiry coincide, the press wins; expiry is re-evaluated from the new state.

Arithmetic and widths:
- remain max = 3*TIMER_UNIT_S, which must be ≤255.
- Speed never leaves 0..5.
- o_fanState upper bits are always 0.

PWM:
- pwm_cnt counts 0..99, advancing once every PWM_DIV clocks, free-running.
- duty = speed*20.
- o_pwm = (pwm_cnt < duty), registered, so 1 cycle latency.
- Speed 0 -> constant 0. Speed 5 -> constant 1.
- A speed change takes effect at the next compare; pwm_cnt is not restarted.

o_running is registered and is 1 exactly when o_fanState != 0.

Test Plan:
Bench parameters: TICK_DIV=10, PWM_DIV=1, TIMER_UNIT_S=3.
- Reset then idle: hold i_reset 3 clk with buttons high -> all outputs 0; releasing buttons after reset produces no press.
- Up held 50 clk, then 6 up pulses -> held gives fanState=1 only; pulses saturate at 5; o_pwm stays 1 over a 100-count window.
- Speed 2, sample 100 counts -> o_pwm high exactly 40 counts; 4 down pulses -> 1, 0 (IDLE), stays 0; o_running falls with state 0.
- Timer cycling at speed 3: timer press -> timerSet=1, remain=3.
  - After 10 clk remain=2.
  - Press again -> set=2, remain=6.
  - Two more presses -> set=0, RUN, remain=0.
- Expiry: timerSet=1 at speed 4 -> remain 3,2,1,0 at 10-clk spacing; on 0, fanState=0, timerSet=0, IDLE.
  - Variant: up press in the expiry cycle -> speed 5 applied first, then expiry.
  - Reset at remain=2 -> all 0.
- Simultaneous presses at speed 3: off+up same cycle -> IDLE, speed 0. up+down same cycle -> speed 4. down+timer -> speed 2, timerSet unchanged.
